ram8x72_fifo_ctrl: RTL
======================

// Module: ram8x72_fifo_ctrl
// PURPOSE
//  Upstream controller for the 8x72 DFF RAM (clk, wr_n, address[2:0], wdata[71:0], rdata[71:0]).
//  Turns the single-port RAM into a 72-bit FIFO with valid/ready streaming on both sides.
//  Drives the RAM's wr_n/address/wdata, consumes rdata, and presents a registered output word.
//  Arbitrates the one RAM access per cycle between a write (push) and a read (prefetch).
// PARAMETERS
//  DATA_W  72  word width; must match the RAM width
//  ADDR_W  3   RAM address width; RAM depth = 2**ADDR_W = 8
// PORTS
//  clk          in   1       rising-edge clock, shared with the RAM
//  rst_n        in   1       asynchronous, active-low reset
//  s_valid      in   1       upstream word valid
//  s_ready      out  1       controller accepts s_data this cycle
//  s_data       in   DATA_W  upstream word
//  m_valid      out  1       output register holds a word
//  m_ready      in   1       downstream consumes m_data this cycle
//  m_data       out  DATA_W  head-of-FIFO word (registered)
//  ram_wr_n     out  1       to RAM wr_n; 0 = write this cycle, 1 = read
//  ram_address  out  ADDR_W  to RAM address
//  ram_wdata    out  DATA_W  to RAM wdata
//  ram_rdata    in   DATA_W  from RAM rdata; valid the cycle after a read cycle
//  level        out  4       words held: RAM + in-flight read + output register (0..9)
// BEHAVIOUR
//  State: wr_ptr, rd_ptr (ADDR_W, wrap 7->0), ram_cnt (0..8), rd_pend (1b), m_valid, m_data.
//  Reset (async, rst_n=0): pointers, ram_cnt, rd_pend, m_valid, m_data = 0. level = 0, s_ready = 0,
//    ram_wr_n = 1. RAM contents are not cleared. An in-flight read is discarded.
//  rd_req  = (ram_cnt != 0) && !m_valid && !rd_pend.  Uses registered state only.
//  s_ready = (ram_cnt != 8) && !rd_req.  There is no combinational path from m_ready to s_ready.
//  Write cycle (s_valid && s_ready):
//    ram_wr_n = 0, ram_address = wr_ptr, ram_wdata = s_data.
//    At the clock edge: wr_ptr++, ram_cnt++.
//  Read cycle (rd_req):
//    ram_wr_n = 1, ram_address = rd_ptr.
//    At the clock edge: rd_ptr++, ram_cnt--, rd_pend = 1.
//  Idle cycle: ram_wr_n = 1, ram_address = rd_ptr, ram_wdata = s_data. ram_* outputs are
//    combinational from registered state and s_valid/s_data.
//  Capture: when rd_pend = 1, at the clock edge m_data <= ram_rdata, m_valid <= 1, rd_pend <= 0.
//  Pop: when m_valid && m_ready, m_valid <= 0 at the edge, unless a capture occurs on the same
//    edge, in which case m_valid stays 1 with the new word.
//  rd_req is 0 whenever rd_pend = 1 or m_valid = 1, so a capture never overwrites an unconsumed word.
//  Latency: a push into an empty FIFO gives m_valid = 1 three edges after acceptance
//    (write, read, capture). Sustained throughput is 1 word per 3 cycles when the RAM is
//    otherwise non-empty.
//  Capacity: 8 in RAM + 1 in the output register = 9. level = ram_cnt + rd_pend + m_valid,
//    registered.
//  Reads and writes never share a cycle. A word written at edge N is readable from cycle N+1.
//  A write and a pop may occur on the same edge; each updates its own state independently.
//  s_valid with s_ready = 0 holds off; s_data must be held stable by the source.
//  m_valid, once set, stays high with m_data stable until m_ready.
// TESTING
//  1. Reset: rst_n = 0 mid-stream -> m_valid = 0, s_ready = 0, level = 0, ram_wr_n = 1, pointers = 0.
//     After release with an idle source -> s_ready = 1.
//  2. Single word: push 72'd1 into an empty FIFO -> ram_wr_n = 0 at address 0, then a read at
//     address 0, then m_valid = 1 with m_data = 72'd1 on the 3rd edge. Pop -> level = 0.
//  3. Fill: m_ready = 0, offer 72'd1..72'd10 -> exactly 9 accepted (72'd1 in the output register,
//     72'd2..72'd9 at addresses 1..7,0), s_ready = 0, level = 9.
//  4. Drain: after test 3, m_ready = 1 -> m_data sequence is 72'd1..72'd9 in order, then m_valid = 0
//     and level = 0. No duplicates or drops.
//  5. Wrap and throughput: stream 72'd1..72'd20 with random s_valid/m_ready -> output order preserved
//     across the 7->0 pointer wrap. ram_wr_n is never 0 in a read cycle.
//  6. Simultaneous push and pop at level 5: level stays 5 and ordering is intact. Assert rst_n
//     during a pending read -> no stale word appears after reset.

Source files
------------

// File: rtl/ram8x72_fifo_ctrl.sv
// ram8x72_fifo_ctrl
// Wraps a single-port 8x72 DFF RAM into a 72-bit valid/ready FIFO. Each cycle the
// RAM does either one write (push) or one read (prefetch into the output register).
// Reads are only issued when the output register and the read pipeline are empty,
// so the prefetch never collides with an unconsumed word.
module ram8x72_fifo_ctrl #(
    parameter int DATA_W = 72,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              ram_wr_n,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [3:0]        level
);

    localparam logic [ADDR_W:0]   CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    // Registered state
    logic              r_run;        // low in reset and the first cycle after it; keeps s_ready low
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_ram_cnt;
    logic              r_rd_pend;
    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [3:0]        r_level;

    // Combinational decisions and next-state values
    logic              w_rd_req;
    logic              w_s_ready;
    logic              w_wr;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [ADDR_W-1:0] w_rd_ptr_nxt;
    logic [ADDR_W:0]   w_ram_cnt_nxt;
    logic              w_rd_pend_nxt;
    logic              w_m_valid_nxt;
    logic [DATA_W-1:0] w_m_data_nxt;
    logic [3:0]        w_level_nxt;

    // Arbitration: prefetch has priority over push; both derived from registered state only
    always_comb begin
        w_rd_req  = 1'b0;
        w_s_ready = 1'b0;
        w_wr      = 1'b0;
        if ((r_ram_cnt != CNT_ZERO) && !r_m_valid && !r_rd_pend) begin
            w_rd_req = 1'b1;
        end else begin
            w_rd_req = 1'b0;
        end
        if (r_run && (r_ram_cnt != CNT_FULL) && !w_rd_req) begin
            w_s_ready = 1'b1;
        end else begin
            w_s_ready = 1'b0;
        end
        w_wr = s_valid && w_s_ready;
    end

    // RAM port drive: write address on push cycles, read pointer otherwise
    always_comb begin
        ram_wr_n    = 1'b1;
        ram_address = r_rd_ptr;
        ram_wdata   = s_data;
        if (w_wr) begin
            ram_wr_n    = 1'b0;
            ram_address = r_wr_ptr;
        end else begin
            ram_wr_n    = 1'b1;
            ram_address = r_rd_ptr;
        end
    end

    // Next-state for pointers, occupancy, read pipeline and output register
    always_comb begin
        w_wr_ptr_nxt  = r_wr_ptr;
        w_rd_ptr_nxt  = r_rd_ptr;
        w_ram_cnt_nxt = r_ram_cnt;
        w_rd_pend_nxt = w_rd_req;
        w_m_valid_nxt = r_m_valid;
        w_m_data_nxt  = r_m_data;
        if (w_wr) begin
            w_wr_ptr_nxt  = r_wr_ptr + PTR_ONE;
            w_ram_cnt_nxt = r_ram_cnt + CNT_ONE;
        end else if (w_rd_req) begin
            w_rd_ptr_nxt  = r_rd_ptr + PTR_ONE;
            w_ram_cnt_nxt = r_ram_cnt - CNT_ONE;
        end else begin
            w_wr_ptr_nxt  = r_wr_ptr;
            w_ram_cnt_nxt = r_ram_cnt;
        end
        // a capture on the same edge as a pop replaces the popped word
        if (r_rd_pend) begin
            w_m_valid_nxt = 1'b1;
            w_m_data_nxt  = ram_rdata;
        end else if (r_m_valid && m_ready) begin
            w_m_valid_nxt = 1'b0;
            w_m_data_nxt  = r_m_data;
        end else begin
            w_m_valid_nxt = r_m_valid;
            w_m_data_nxt  = r_m_data;
        end
        w_level_nxt = 4'(w_ram_cnt_nxt) + {3'b000, w_rd_pend_nxt} + {3'b000, w_m_valid_nxt};
    end

    // Control state register; an in-flight read is dropped by clearing r_rd_pend
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run     <= 1'b0;
            r_wr_ptr  <= {ADDR_W{1'b0}};
            r_rd_ptr  <= {ADDR_W{1'b0}};
            r_ram_cnt <= CNT_ZERO;
            r_rd_pend <= 1'b0;
            r_m_valid <= 1'b0;
            r_level   <= 4'd0;
        end else begin
            r_run     <= 1'b1;
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_ram_cnt <= w_ram_cnt_nxt;
            r_rd_pend <= w_rd_pend_nxt;
            r_m_valid <= w_m_valid_nxt;
            r_level   <= w_level_nxt;
        end
    end

    // Output data register, held stable until a new word is captured
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_data <= {DATA_W{1'b0}};
        end else begin
            r_m_data <= w_m_data_nxt;
        end
    end

    assign s_ready = w_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign level   = r_level;

endmodule
